// File: rtl/grant_route_demux.sv
// Fans one TileLink Grant stream out to 4 client ports through a single registered stage,
// locking the route for the whole of a multibeat Grant. Optional checker: GRANT_ROUTE_CHECK_EN.
module grant_route_demux #(
    parameter int N_BEATS = 8,
    parameter int DATA_W  = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [1:0]        io_in_bits_client_id,
    input  logic [2:0]        io_in_bits_addr_beat,
    input  logic [1:0]        io_in_bits_client_xact_id,
    input  logic              io_in_bits_manager_xact_id,
    input  logic              io_in_bits_is_builtin_type,
    input  logic [3:0]        io_in_bits_g_type,
    input  logic [DATA_W-1:0] io_in_bits_data,

    output logic              io_out_0_valid,
    input  logic              io_out_0_ready,
    output logic              io_out_1_valid,
    input  logic              io_out_1_ready,
    output logic              io_out_2_valid,
    input  logic              io_out_2_ready,
    output logic              io_out_3_valid,
    input  logic              io_out_3_ready,

    output logic [2:0]        io_out_bits_addr_beat,
    output logic [1:0]        io_out_bits_client_xact_id,
    output logic              io_out_bits_manager_xact_id,
    output logic              io_out_bits_is_builtin_type,
    output logic [3:0]        io_out_bits_g_type,
    output logic [DATA_W-1:0] io_out_bits_data,

    output logic [1:0]        io_route,
    output logic              io_locked
`ifdef GRANT_ROUTE_CHECK_EN
    ,
    output logic              io_err
`endif
);

    localparam int CNT_W = $clog2(N_BEATS);

    // Handshake contract: a beat moves on any port when its valid and ready are both high at
    // the rising clock edge; valid and payload are held stable until that happens.
    logic              r_q_valid;
    logic [1:0]        r_q_dest;
    logic [2:0]        r_q_addr_beat;
    logic [1:0]        r_q_client_xact_id;
    logic              r_q_manager_xact_id;
    logic              r_q_is_builtin_type;
    logic [3:0]        r_q_g_type;
    logic [DATA_W-1:0] r_q_data;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [1:0]        r_lock_dest;

    logic              w_mb;
    logic              w_locked;
    logic [1:0]        w_dest;
    logic              w_sel_ready;
    logic              w_out_fire;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_count;

    assign w_mb     = io_in_bits_is_builtin_type ? (io_in_bits_g_type == 4'h5)
                                                 : (io_in_bits_g_type == 4'h0);
    assign w_locked = (r_beat_cnt != '0);
    assign w_dest   = w_locked ? r_lock_dest : io_in_bits_client_id;

    always_comb begin
        w_sel_ready = 1'b0;
        case (r_q_dest)
            2'd0:    w_sel_ready = io_out_0_ready;
            2'd1:    w_sel_ready = io_out_1_ready;
            2'd2:    w_sel_ready = io_out_2_ready;
            default: w_sel_ready = io_out_3_ready;
        endcase
    end

    assign w_out_fire = r_q_valid & w_sel_ready;
    assign w_in_ready = ~r_q_valid | w_out_fire;
    assign w_in_fire  = io_in_valid & w_in_ready;
    // A beat arriving while locked is always a burst beat, even if its type says otherwise.
    assign w_count    = w_in_fire & (w_mb | w_locked);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q_valid           <= 1'b0;
            r_q_dest            <= 2'd0;
            r_q_addr_beat       <= 3'd0;
            r_q_client_xact_id  <= 2'd0;
            r_q_manager_xact_id <= 1'b0;
            r_q_is_builtin_type <= 1'b0;
            r_q_g_type          <= 4'd0;
            r_q_data            <= '0;
        end else if (w_in_fire) begin
            r_q_valid           <= 1'b1;
            r_q_dest            <= w_dest;
            r_q_addr_beat       <= io_in_bits_addr_beat;
            r_q_client_xact_id  <= io_in_bits_client_xact_id;
            r_q_manager_xact_id <= io_in_bits_manager_xact_id;
            r_q_is_builtin_type <= io_in_bits_is_builtin_type;
            r_q_g_type          <= io_in_bits_g_type;
            r_q_data            <= io_in_bits_data;
        end else if (w_out_fire) begin
            r_q_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat_cnt  <= '0;
            r_lock_dest <= 2'd0;
        end else if (w_count) begin
            r_beat_cnt <= r_beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (!w_locked) begin
                r_lock_dest <= io_in_bits_client_id;
            end
        end
    end

`ifdef GRANT_ROUTE_CHECK_EN
    logic       r_err;
    logic [2:0] w_cnt_ext;
    logic       w_err_hit;

    assign w_cnt_ext = 3'(r_beat_cnt);
    assign w_err_hit = (w_locked && (io_in_bits_client_id != r_lock_dest)) ||
                       (w_mb && (io_in_bits_addr_beat != w_cnt_ext));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_in_fire && w_err_hit) begin
            r_err <= 1'b1;
        end
    end

    assign io_err = r_err;
`endif

    assign io_in_ready = w_in_ready;

    assign io_out_0_valid = r_q_valid & (r_q_dest == 2'd0);
    assign io_out_1_valid = r_q_valid & (r_q_dest == 2'd1);
    assign io_out_2_valid = r_q_valid & (r_q_dest == 2'd2);
    assign io_out_3_valid = r_q_valid & (r_q_dest == 2'd3);

    assign io_out_bits_addr_beat       = r_q_addr_beat;
    assign io_out_bits_client_xact_id  = r_q_client_xact_id;
    assign io_out_bits_manager_xact_id = r_q_manager_xact_id;
    assign io_out_bits_is_builtin_type = r_q_is_builtin_type;
    assign io_out_bits_g_type          = r_q_g_type;
    assign io_out_bits_data            = r_q_data;

    assign io_route  = r_q_dest;
    assign io_locked = w_locked;

endmodule
